uart_echo_fifo_display: RTL and testbench

Buffered UART echo engine with a hex history display. It sits between the existing UART receiver and transmitter. Received bytes go into a FIFO, and a TX pump state machine drains the FIFO into the transmitter one byte at a time with a proper handshake. The last DISP_BYTES received bytes are shown as hex on 7-segment digits.

---
 rtl/uart_echo_pkg.sv | 46 ++++
 rtl/hex_digit_seg_reg.sv | 35 +++
 rtl/uart_echo_fifo_display.sv | 173 +++++++++++++++++
 tb/tb_uart_echo_fifo_display.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// Shared definitions for the buffered UART echo engine: TX pump states,
// the 7-segment hex font and the lowercase-to-uppercase conversion constants.
// The optional uppercase echo is selected with the UART_ECHO_UPPERCASE_EN macro.
package uart_echo_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_ACTIVE = 2'd1,
      WAIT_DONE   = 2'd2
   } pump_state_t;

   localparam int SEG_W = 7;

   // Segment patterns in {A,B,C,D,E,F,G} order, active-high, indexed by nibble.
   localparam logic [SEG_W-1:0] HEX_SEG_TABLE [16] = '{
      7'b1111110,  // 0
      7'b0110000,  // 1
      7'b1101101,  // 2
      7'b1111001,  // 3
      7'b0110011,  // 4
      7'b1011011,  // 5
      7'b1011111,  // 6
      7'b1110000,  // 7
      7'b1111111,  // 8
      7'b1111011,  // 9
      7'b1110111,  // A
      7'b0011111,  // b
      7'b1001110,  // C
      7'b0111101,  // d
      7'b1001111,  // E
      7'b1000111   // F
   };

   localparam logic [7:0] LOWER_A     = 8'h61;
   localparam logic [7:0] LOWER_Z     = 8'h7A;
   localparam logic [7:0] CASE_OFFSET = 8'h20;

   // ASCII 'a'..'z' become 'A'..'Z'; every other byte passes through untouched.
   function automatic logic [7:0] to_upper(input logic [7:0] b);
      if ((b >= LOWER_A) && (b <= LOWER_Z)) begin
         return b - CASE_OFFSET;
      end
      return b;
   endfunction

endpackage

// File: rtl/hex_digit_seg_reg.sv
// One registered hex digit: a nibble in, a 7-segment pattern out one clock later.
// Polarity follows SEG_ACTIVE_LOW so common-anode boards get inverted outputs.
module hex_digit_seg_reg
   import uart_echo_pkg::*;
#(
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg
);

   localparam bit INVERT = (SEG_ACTIVE_LOW != 0);

   logic [SEG_W-1:0] seg_next;

   // Look up the font and apply board polarity.
   always_comb begin
      seg_next = HEX_SEG_TABLE[nibble];
      if (INVERT) begin
         seg_next = ~HEX_SEG_TABLE[nibble];
      end
   end

   // Register the decoded pattern; reset shows "0" in the board's polarity.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= INVERT ? ~HEX_SEG_TABLE[0] : HEX_SEG_TABLE[0];
      end else begin
         seg <= seg_next;
      end
   end

endmodule

// File: rtl/uart_echo_fifo_display.sv
// Buffered UART echo: received bytes are queued in a FIFO and pumped into the
// transmitter one at a time; the newest DISP_BYTES received bytes are shown in hex.
// Defining UART_ECHO_UPPERCASE_EN converts 'a'..'z' to uppercase on the way out.
module uart_echo_fifo_display
   import uart_echo_pkg::*;
#(
   parameter int FIFO_DEPTH     = 16,
   parameter int DISP_BYTES     = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                               i_Clk,
   input  logic                               i_Rst,
   input  logic                               i_RX_DV,
   input  logic [7:0]                         i_RX_Byte,
   input  logic                               i_TX_Active,
   input  logic                               i_TX_Done,
   output logic                               o_TX_DV,
   output logic [7:0]                         o_TX_Byte,
   output logic [14*DISP_BYTES-1:0]           o_Segments,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_Fill_Level,
   output logic                               o_Overflow
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   localparam int PW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] DEPTH_L = PW'(FIFO_DEPTH);

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] fill;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          drop;
   logic [7:0]    head;
   logic [7:0]    tx_next;

   pump_state_t   state;
   pump_state_t   state_next;

   logic [7:0]    disp_reg [DISP_BYTES];

   assign fill         = wr_ptr - rd_ptr;
   assign full         = (fill == DEPTH_L);
   assign empty        = (fill == '0);
   assign push         = i_RX_DV && (!full || pop);
   assign drop         = i_RX_DV && full && !pop;
   assign head         = fifo_mem[rd_ptr[AW-1:0]];
   assign o_Fill_Level = fill;

`ifdef UART_ECHO_UPPERCASE_EN
   assign tx_next = to_upper(head);
`else
   assign tx_next = head;
`endif

   // Advance the write pointer on accepted pushes and the read pointer on pops.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // FIFO storage; a full-FIFO push that coincides with a pop reuses the slot being read.
   always_ff @(posedge i_Clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= i_RX_Byte;
      end
   end

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Overflow <= 1'b0;
      end else if (drop) begin
         o_Overflow <= 1'b1;
      end
   end

   // TX pump state register.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // TX pump transitions; a pop only happens from IDLE with the transmitter free.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !i_TX_Active) begin
               pop        = 1'b1;
               state_next = WAIT_ACTIVE;
            end
         end
         WAIT_ACTIVE: begin
            if (i_TX_Done) begin
               state_next = IDLE;
            end else if (i_TX_Active) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (i_TX_Done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Launch strobe is a single cycle; the byte is held until the next launch.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_TX_DV   <= 1'b0;
         o_TX_Byte <= 8'h00;
      end else begin
         o_TX_DV <= pop;
         if (pop) begin
            o_TX_Byte <= tx_next;
         end
      end
   end

   // Display history shifts on every strobe, including dropped bytes; newest at index 0.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         for (int i = 0; i < DISP_BYTES; i++) begin
            disp_reg[i] <= 8'h00;
         end
      end else if (i_RX_DV) begin
         for (int i = DISP_BYTES - 1; i >= 1; i--) begin
            disp_reg[i] <= disp_reg[i-1];
         end
         disp_reg[0] <= i_RX_Byte;
      end
   end

   for (genvar b = 0; b < DISP_BYTES; b++) begin : g_digits
      hex_digit_seg_reg #(
         .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
      ) u_lo (
         .clk    (i_Clk),
         .rst    (i_Rst),
         .nibble (disp_reg[b][3:0]),
         .seg    (o_Segments[14*b +: SEG_W])
      );
      hex_digit_seg_reg #(
         .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
      ) u_hi (
         .clk    (i_Clk),
         .rst    (i_Rst),
         .nibble (disp_reg[b][7:4]),
         .seg    (o_Segments[14*b + 7 +: SEG_W])
      );
   end

endmodule

// File: tb/tb_uart_echo_fifo_display.sv
// Self-checking bench for uart_echo_fifo_display (default parameters, active-low
// segments). A behavioural transmitter answers launches; a queue holds the
// bytes expected on the TX side in order.
module tb_uart_echo_fifo_display;

   logic        i_Clk;
   logic        i_Rst;
   logic        i_RX_DV;
   logic [7:0]  i_RX_Byte;
   logic        i_TX_Active;
   logic        i_TX_Done;
   logic        o_TX_DV;
   logic [7:0]  o_TX_Byte;
   logic [13:0] o_Segments;
   logic [4:0]  o_Fill_Level;
   logic        o_Overflow;

   logic        force_busy;
   logic        model_active;
   int          model_count;
   int          tx_len;
   logic [7:0]  cur_byte;
   logic        skip_hold;

   int          checks;
   int          failures;
   logic [7:0]  exp_q [$];

   typedef struct {
      logic [7:0]  rx;
      logic [13:0] exp_seg;
      logic [7:0]  exp_tx;
   } vec_t;

   vec_t vecs [12];

   assign i_TX_Active = force_busy | model_active;

   uart_echo_fifo_display #(
      .FIFO_DEPTH     (16),
      .DISP_BYTES     (1),
      .SEG_ACTIVE_LOW (1)
   ) dut (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_RX_DV      (i_RX_DV),
      .i_RX_Byte    (i_RX_Byte),
      .i_TX_Active  (i_TX_Active),
      .i_TX_Done    (i_TX_Done),
      .o_TX_DV      (o_TX_DV),
      .o_TX_Byte    (o_TX_Byte),
      .o_Segments   (o_Segments),
      .o_Fill_Level (o_Fill_Level),
      .o_Overflow   (o_Overflow)
   );

   initial begin
      i_Clk = 1'b0;
      forever #5 i_Clk = ~i_Clk;
   end

   // Byte the transmitter should see for a received byte.
   function automatic logic [7:0] exp_echo(input logic [7:0] b);
`ifdef UART_ECHO_UPPERCASE_EN
      if (b >= 8'h61 && b <= 8'h7A) begin
         return b - 8'h20;
      end
`endif
      return b;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Transmitter model: goes busy on a launch, finishes tx_len cycles later.
   initial begin
      model_active = 1'b0;
      model_count  = 0;
      i_TX_Done    = 1'b0;
      cur_byte     = 8'h00;
      forever begin
         @(negedge i_Clk);
         i_TX_Done = 1'b0;
         if (model_count > 0) begin
            model_count--;
            if (model_count == 0) begin
               i_TX_Done    = 1'b1;
               model_active = 1'b0;
               if (!skip_hold) begin
                  check_output("tx_byte_held", o_TX_Byte, cur_byte);
               end
            end
         end
         if (o_TX_DV) begin
            check_output("launch_while_busy", model_active, 1'b0);
            check_output("launch_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               check_output("tx_byte_order", o_TX_Byte, exp_q.pop_front());
            end
            cur_byte     = o_TX_Byte;
            skip_hold    = 1'b0;
            model_active = 1'b1;
            model_count  = tx_len;
         end
      end
   end

   task automatic reset_dut();
      i_Rst   = 1'b1;
      i_RX_DV = 1'b0;
      @(negedge i_Clk);
      @(negedge i_Clk);
      exp_q.delete();
      i_Rst = 1'b0;
      @(negedge i_Clk);
   endtask

   // Drive one receive strobe for a single cycle; queue its echo if it will be accepted.
   task automatic apply_stimulus(input logic [7:0] b, input logic accepted);
      i_RX_DV   = 1'b1;
      i_RX_Byte = b;
      if (accepted) begin
         exp_q.push_back(exp_echo(b));
      end
      @(negedge i_Clk);
      i_RX_DV = 1'b0;
   endtask

   // Let the pump empty the FIFO and the transmitter go idle, within a cycle budget.
   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || model_active || o_Fill_Level != 0) && n < budget) begin
         @(negedge i_Clk);
         n++;
      end
      check_output("drain_in_budget", n < budget, 1'b1);
      @(negedge i_Clk);
      @(negedge i_Clk);
   endtask

   initial begin
      int dv_seen;
      int n;
      checks     = 0;
      failures   = 0;
      force_busy = 1'b0;
      skip_hold  = 1'b0;
      tx_len     = 10;
      i_Rst      = 1'b1;
      i_RX_DV    = 1'b0;
      i_RX_Byte  = 8'h00;

      vecs[0]  = '{8'h5A, 14'b0100100_0001000, exp_echo(8'h5A)};
      vecs[1]  = '{8'h00, 14'b0000001_0000001, exp_echo(8'h00)};
      vecs[2]  = '{8'h18, 14'b1001111_0000000, exp_echo(8'h18)};
      vecs[3]  = '{8'hF1, 14'b0111000_1001111, exp_echo(8'hF1)};
      vecs[4]  = '{8'hBC, 14'b1100000_0110001, exp_echo(8'hBC)};
      vecs[5]  = '{8'h3D, 14'b0000110_1000010, exp_echo(8'h3D)};
      vecs[6]  = '{8'h29, 14'b0010010_0000100, exp_echo(8'h29)};
      vecs[7]  = '{8'hE6, 14'b0110000_0100000, exp_echo(8'hE6)};
      vecs[8]  = '{8'h61, 14'b0100000_1001111, exp_echo(8'h61)};
      vecs[9]  = '{8'h7A, 14'b0001111_0001000, exp_echo(8'h7A)};
      vecs[10] = '{8'h7B, 14'b0001111_1100000, exp_echo(8'h7B)};
      vecs[11] = '{8'h40, 14'b1001100_0000001, exp_echo(8'h40)};

      // Reset state and a quiet idle period.
      reset_dut();
      check_output("rst_segments", o_Segments, 14'b0000001_0000001);
      check_output("rst_fill", o_Fill_Level, 5'd0);
      check_output("rst_overflow", o_Overflow, 1'b0);
      check_output("rst_tx_dv", o_TX_DV, 1'b0);
      check_output("rst_tx_byte", o_TX_Byte, 8'h00);
      dv_seen = 0;
      repeat (8) begin
         @(negedge i_Clk);
         if (o_TX_DV) dv_seen++;
      end
      check_output("idle_no_dv", dv_seen, 0);

      // Table: single bytes with an idle transmitter, latency and display checks.
      tx_len = 10;
      for (int v = 0; v < 12; v++) begin
         apply_stimulus(vecs[v].rx, 1'b1);
         check_output("launch_not_early", o_TX_DV, 1'b0);
         @(negedge i_Clk);
         check_output("launch_at_2", o_TX_DV, 1'b1);
         check_output("launch_byte", o_TX_Byte, vecs[v].exp_tx);
         check_output("segments", o_Segments, vecs[v].exp_seg);
         @(negedge i_Clk);
         check_output("dv_one_cycle", o_TX_DV, 1'b0);
         wait_drain(60);
      end

      // Burst of 20 into a stalled transmitter: the last 4 are dropped.
      force_busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(8'(i), i < 16);
      end
      check_output("burst_fill", o_Fill_Level, 5'd16);
      check_output("burst_overflow", o_Overflow, 1'b1);
      @(negedge i_Clk);
      check_output("burst_seg_newest", o_Segments, 14'b1001111_0000110);
      check_output("burst_fill_hold", o_Fill_Level, 5'd16);
      tx_len     = 3;
      force_busy = 1'b0;
      wait_drain(400);
      check_output("overflow_sticky", o_Overflow, 1'b1);

      // Full FIFO with a push in the same cycle as an IDLE pop.
      reset_dut();
      check_output("rst2_overflow", o_Overflow, 1'b0);
      force_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(8'h80 + 8'(i), 1'b1);
      end
      check_output("full_fill", o_Fill_Level, 5'd16);
      force_busy = 1'b0;
      apply_stimulus(8'h90, 1'b1);
      check_output("pushpop_fill", o_Fill_Level, 5'd16);
      check_output("pushpop_overflow", o_Overflow, 1'b0);
      check_output("pushpop_dv", o_TX_DV, 1'b1);
      check_output("pushpop_byte", o_TX_Byte, 8'h80);
      wait_drain(400);
      check_output("pushpop_overflow_end", o_Overflow, 1'b0);

      // Reset while in WAIT_DONE with three bytes queued.
      reset_dut();
      tx_len = 20;
      apply_stimulus(8'hC1, 1'b1);
      n = 0;
      while (!model_active && n < 10) begin
         @(negedge i_Clk);
         n++;
      end
      check_output("c1_launched", model_active, 1'b1);
      apply_stimulus(8'hC2, 1'b0);
      apply_stimulus(8'hC3, 1'b0);
      apply_stimulus(8'hC4, 1'b0);
      check_output("queued_fill", o_Fill_Level, 5'd3);
      skip_hold = 1'b1;
      i_Rst     = 1'b1;
      @(negedge i_Clk);
      check_output("midrst_fill", o_Fill_Level, 5'd0);
      check_output("midrst_dv", o_TX_DV, 1'b0);
      exp_q.delete();
      i_Rst = 1'b0;
      @(negedge i_Clk);
      check_output("still_busy", model_active, 1'b1);
      apply_stimulus(8'hC5, 1'b1);
      dv_seen = 0;
      n       = 0;
      while (model_active && n < 40) begin
         if (o_TX_DV) dv_seen++;
         @(negedge i_Clk);
         n++;
      end
      check_output("no_launch_while_busy", dv_seen, 0);
      tx_len = 3;
      wait_drain(60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
